// File: rtl/pkt_dequeue_ctrl_pkg.sv
// Shared types and constants for the packet dequeue controller.
package pkt_dequeue_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int FIFO_DEPTH   = 2;
  localparam int DESC_ADDR_W  = 12;
  localparam int DESC_LEN_W   = 8;

endpackage

// File: rtl/pkt_dequeue_ctrl_axis_fifo2.sv
// Two-entry registered FIFO; head register drives the output directly.
module axis_fifo2
  import pkt_dequeue_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [1:0]       count
);

  localparam logic [1:0] FULL = 2'(FIFO_DEPTH);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  // a pop frees a slot in the same cycle, so push is legal even when full
  assign do_pop  = pop & (cnt != 2'd0);
  assign do_push = push & ((cnt != FULL) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case (cnt)
        2'd0: begin
          if (do_push) head <= push_data;
        end
        2'd1: begin
          if (do_push) begin
            if (do_pop) head <= push_data;
            else        tail <= push_data;
          end
        end
        default: begin
          if (do_pop)  head <= tail;
          if (do_push) tail <= push_data;
        end
      endcase
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign pop_data = head;
  assign valid    = (cnt != 2'd0);
  assign count    = cnt;

endmodule

// File: rtl/pkt_dequeue_ctrl.sv
// Walks a buffered packet's word list and streams it out over AXI4-Stream.
module pkt_dequeue_ctrl
  import pkt_dequeue_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = DESC_ADDR_W,
  parameter int LEN_WIDTH      = DESC_LEN_W,
  parameter int DATA_WIDTH     = 256,
  parameter int TUSER_WIDTH    = 128,
  parameter int BUF_RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_desc_valid,
  output logic                    s_desc_ready,
  input  logic [ADDR_WIDTH-1:0]   s_desc_sop_addr,
  input  logic [LEN_WIDTH-1:0]    s_desc_len,
  output logic                    buf_rd_first_word_en,
  output logic                    buf_rd_en,
  output logic [ADDR_WIDTH-1:0]   buf_rd_pkt_sop_addr,
  input  logic [DATA_WIDTH-1:0]   buf_tdata,
  input  logic [DATA_WIDTH/8-1:0] buf_tkeep,
  input  logic                    buf_tlast,
  input  logic [TUSER_WIDTH-1:0]  buf_tuser,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [31:0]             stat_pkt_count,
  output logic                    err_len_mismatch
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int PAY_W  = TUSER_WIDTH + 1 + KEEP_W + DATA_WIDTH;
  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t                    state;
  state_t                    state_nxt;
  logic [ADDR_WIDTH-1:0]     sop_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [LEN_WIDTH-1:0]      words_left;
  logic [LEN_WIDTH-1:0]      pos;
  logic [LEN_WIDTH-1:0]      len_eff;
  logic                      first_q;
  logic [BUF_RD_LATENCY-1:0] rd_pipe;
  logic                      inflight;
  logic [1:0]                fifo_count;
  logic [31:0]               pkt_cnt;
  logic                      err_q;
  logic                      accept;
  logic                      pop;
  logic                      credit_ok;
  logic                      issue;
  logic                      last_issue;
  logic                      tlast_bad;
  logic [PAY_W-1:0]          fifo_in;
  logic [PAY_W-1:0]          fifo_out;

  assign len_eff    = (s_desc_len == '0) ? ONE : s_desc_len;
  assign accept     = s_desc_valid & s_desc_ready;
  assign pop        = m_axis_tvalid & m_axis_tready;
  // words already owed to the FIFO, net of the beat leaving this cycle
  assign credit_ok  = (({1'b0, fifo_count} + {2'b00, inflight})
                       - {2'b00, pop}) < 3'd2;
  assign issue      = (state == ISSUE) & credit_ok;
  assign last_issue = issue & (words_left == ONE);
  assign inflight   = rd_pipe[BUF_RD_LATENCY-1];
  assign tlast_bad  = inflight & (buf_tlast != (pos == len_q - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)     state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_desc_ready         = (state == IDLE) & ~rst;
    buf_rd_first_word_en = issue & first_q;
    buf_rd_en            = issue & ~first_q;
    buf_rd_pkt_sop_addr  = buf_rd_first_word_en ? sop_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sop_q      <= '0;
      len_q      <= ONE;
      words_left <= '0;
      first_q    <= 1'b0;
      rd_pipe    <= '0;
      pos        <= '0;
      pkt_cnt    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        sop_q      <= s_desc_sop_addr;
        len_q      <= len_eff;
        words_left <= len_eff;
        first_q    <= 1'b1;
      end else if (issue) begin
        words_left <= words_left - ONE;
        first_q    <= 1'b0;
      end
      rd_pipe <= BUF_RD_LATENCY'({rd_pipe, issue});
      if (inflight) pos <= (pos == len_q - ONE) ? '0 : pos + ONE;
      if (last_issue) pkt_cnt <= pkt_cnt + 32'd1;
      if ((accept & (s_desc_len == '0)) | tlast_bad) err_q <= 1'b1;
    end
  end

  assign fifo_in = {buf_tuser, buf_tlast, buf_tkeep, buf_tdata};

  axis_fifo2 #(
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_in),
    .pop       (pop),
    .pop_data  (fifo_out),
    .valid     (m_axis_tvalid),
    .count     (fifo_count)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_out;
  assign stat_pkt_count   = pkt_cnt;
  assign err_len_mismatch = err_q;

endmodule

// File: tb/tb_pkt_dequeue_ctrl.sv
// Directed bench for pkt_dequeue_ctrl with a behavioural packet buffer.
module tb_pkt_dequeue_ctrl;

  localparam int AW = 12;
  localparam int LW = 8;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_desc_valid;
  logic          s_desc_ready;
  logic [AW-1:0] s_desc_sop_addr;
  logic [LW-1:0] s_desc_len;
  logic          buf_rd_first_word_en;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_pkt_sop_addr;
  logic [DW-1:0] buf_tdata;
  logic [KW-1:0] buf_tkeep;
  logic          buf_tlast;
  logic [UW-1:0] buf_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [31:0]   stat_pkt_count;
  logic          err_len_mismatch;

  always #5 clk = ~clk;

  pkt_dequeue_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_desc_valid         (s_desc_valid),
    .s_desc_ready         (s_desc_ready),
    .s_desc_sop_addr      (s_desc_sop_addr),
    .s_desc_len           (s_desc_len),
    .buf_rd_first_word_en (buf_rd_first_word_en),
    .buf_rd_en            (buf_rd_en),
    .buf_rd_pkt_sop_addr  (buf_rd_pkt_sop_addr),
    .buf_tdata            (buf_tdata),
    .buf_tkeep            (buf_tkeep),
    .buf_tlast            (buf_tlast),
    .buf_tuser            (buf_tuser),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tkeep         (m_axis_tkeep),
    .m_axis_tuser         (m_axis_tuser),
    .m_axis_tlast         (m_axis_tlast),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tready        (m_axis_tready),
    .stat_pkt_count       (stat_pkt_count),
    .err_len_mismatch     (err_len_mismatch)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] w(input logic [11:0] a, input int i);
    return {12'h000, a, 8'(i)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // packet buffer model: one-cycle read latency
  logic [7:0]  lens[$];
  int          cur_len;
  int          idx;
  int          early_idx = -1;
  logic [11:0] base;

  always @(posedge clk) begin
    if (rst) begin
      lens.delete();
      buf_tdata <= '0;
      buf_tkeep <= '0;
      buf_tlast <= 1'b0;
      buf_tuser <= '0;
    end else if (buf_rd_first_word_en || buf_rd_en) begin
      if (buf_rd_first_word_en) begin
        idx     = 0;
        base    = buf_rd_pkt_sop_addr;
        cur_len = (lens.size() > 0) ? int'(lens.pop_front()) : 1;
      end else begin
        idx++;
      end
      buf_tdata <= DW'(w(base, idx));
      buf_tkeep <= '1;
      buf_tuser <= UW'(idx);
      buf_tlast <= (early_idx >= 0) ? (idx == early_idx)
                                    : (idx == cur_len - 1);
    end
  end

  // tready pattern 1,0,0,1 while backpressure is enabled
  logic bp_en = 1'b0;
  always @(posedge clk) begin
    #1;
    m_axis_tready = bp_en ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  end

  logic [32:0] beat_q[$];
  int          beat_cyc[$];
  int          first_cyc[$];
  int          rd_cyc[$];
  logic [11:0] first_addr[$];
  bit          ready_log[4096];
  logic        stall = 1'b0;
  logic [31:0] stall_data;

  always @(negedge clk) begin
    if (!rst) begin
      ready_log[cyc % 4096] = s_desc_ready;
      if (buf_rd_first_word_en) begin
        first_cyc.push_back(cyc);
        first_addr.push_back(buf_rd_pkt_sop_addr);
      end
      if (buf_rd_en) rd_cyc.push_back(cyc);
      if (buf_rd_en || buf_rd_first_word_en)
        chk("both_en", 64'(buf_rd_en & buf_rd_first_word_en), 0);
      if (bp_en) begin
        chk("credit", 64'((32'(dut.fifo_count) + 32'(dut.inflight)) <= 2), 1);
        if (stall && m_axis_tvalid)
          chk("stall_stable", 64'(m_axis_tdata[31:0]), 64'(stall_data));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beat_q.push_back({m_axis_tlast, m_axis_tdata[31:0]});
        beat_cyc.push_back(cyc);
      end
      stall      = m_axis_tvalid & ~m_axis_tready;
      stall_data = m_axis_tdata[31:0];
    end else begin
      stall = 1'b0;
    end
  end

  task automatic clear_logs();
    beat_q.delete();
    beat_cyc.delete();
    first_cyc.delete();
    rd_cyc.delete();
    first_addr.delete();
  endtask

  task automatic send(input logic [11:0] a, input logic [7:0] l);
    int n = 0;
    s_desc_valid    = 1'b1;
    s_desc_sop_addr = a;
    s_desc_len      = l;
    lens.push_back((l == 0) ? 8'd1 : l);
    while (!s_desc_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("desc_timeout", 64'(s_desc_ready), 1);
    @(negedge clk);
    s_desc_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k = 0;
    while (beat_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("beat_timeout", 64'(beat_q.size()), 64'(n));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int seen;
    int n;
    int l_last;
    logic [32:0] exp_b2b[6];
    rst             = 1'b1;
    s_desc_valid    = 1'b0;
    s_desc_sop_addr = '0;
    s_desc_len      = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(s_desc_ready), 0);
    chk("rst_first", 64'(buf_rd_first_word_en), 0);
    chk("rst_rd", 64'(buf_rd_en), 0);
    chk("rst_tvalid", 64'(m_axis_tvalid), 0);
    chk("rst_stat", 64'(stat_pkt_count), 0);
    chk("rst_err", 64'(err_len_mismatch), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(s_desc_ready), 1);

    // single-word packet
    clear_logs();
    send(12'h005, 8'd1);
    wait_beats(1);
    chk("t1_nfirst", 64'(first_cyc.size()), 1);
    chk("t1_addr", 64'(first_addr[0]), 64'h005);
    chk("t1_nrd", 64'(rd_cyc.size()), 0);
    chk("t1_lat", 64'(beat_cyc[0] - first_cyc[0]), 2);
    chk("t1_beat", 64'(beat_q[0]), 64'({1'b1, w(12'h005, 0)}));
    chk("t1_nbeats", 64'(beat_q.size()), 1);
    chk("t1_stat", 64'(stat_pkt_count), 1);
    chk("t1_err", 64'(err_len_mismatch), 0);

    // four words, tready high
    clear_logs();
    send(12'h010, 8'd4);
    wait_beats(4);
    chk("t2_addr", 64'(first_addr[0]), 64'h010);
    chk("t2_nrd", 64'(rd_cyc.size()), 3);
    for (int i = 0; i < 3; i++)
      chk("t2_rd_cyc", 64'(rd_cyc[i] - first_cyc[0]), 64'(i + 1));
    for (int i = 0; i < 4; i++) begin
      chk("t2_beat", 64'(beat_q[i]), 64'({i == 3, w(12'h010, i)}));
      chk("t2_beat_cyc", 64'(beat_cyc[i] - first_cyc[0]), 64'(i + 2));
    end
    l_last = rd_cyc[2];
    chk("t2_rdy_busy", 64'(ready_log[l_last % 4096]), 0);
    chk("t2_rdy_back", 64'(ready_log[(l_last + 1) % 4096]), 1);
    chk("t2_stat", 64'(stat_pkt_count), 2);

    // eight words under backpressure
    clear_logs();
    bp_en = 1'b1;
    send(12'h020, 8'd8);
    wait_beats(8);
    bp_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t3_nbeats", 64'(beat_q.size()), 8);
    for (int i = 0; i < 8; i++)
      chk("t3_beat", 64'(beat_q[i]), 64'({i == 7, w(12'h020, i)}));
    chk("t3_stat", 64'(stat_pkt_count), 3);

    // back-to-back descriptors
    clear_logs();
    send(12'h100, 8'd2);
    send(12'h200, 8'd3);
    send(12'h300, 8'd1);
    wait_beats(6);
    chk("t4_addr0", 64'(first_addr[0]), 64'h100);
    chk("t4_addr1", 64'(first_addr[1]), 64'h200);
    chk("t4_addr2", 64'(first_addr[2]), 64'h300);
    chk("t4_gap01", 64'(first_cyc[1] - first_cyc[0]), 3);
    chk("t4_gap12", 64'(first_cyc[2] - first_cyc[1]), 4);
    exp_b2b[0] = {1'b0, w(12'h100, 0)};
    exp_b2b[1] = {1'b1, w(12'h100, 1)};
    exp_b2b[2] = {1'b0, w(12'h200, 0)};
    exp_b2b[3] = {1'b0, w(12'h200, 1)};
    exp_b2b[4] = {1'b1, w(12'h200, 2)};
    exp_b2b[5] = {1'b1, w(12'h300, 0)};
    chk("t4_nbeats", 64'(beat_q.size()), 6);
    for (int i = 0; i < 6; i++)
      chk("t4_beat", 64'(beat_q[i]), 64'(exp_b2b[i]));
    chk("t4_stat", 64'(stat_pkt_count), 6);
    chk("t4_err", 64'(err_len_mismatch), 0);

    // early tlast on a len=3 packet
    clear_logs();
    early_idx = 1;
    send(12'h040, 8'd3);
    wait_beats(3);
    early_idx = -1;
    chk("t5_tlast1", 64'(beat_q[1][32]), 1);
    chk("t5_tlast2", 64'(beat_q[2][32]), 0);
    chk("t5_err", 64'(err_len_mismatch), 1);
    clear_logs();
    send(12'h050, 8'd2);
    wait_beats(2);
    chk("t5_sticky", 64'(err_len_mismatch), 1);
    chk("t5_stat", 64'(stat_pkt_count), 8);

    // reset during word 3 of a six-word packet
    clear_logs();
    send(12'h400, 8'd6);
    seen = 0;
    n    = 0;
    while (n < 20) begin
      if (buf_rd_en) seen++;
      if (seen == 2) break;
      @(negedge clk);
      n++;
    end
    chk("t6_reached", 64'(seen), 2);
    rst = 1'b1;
    #1;
    chk("t6_rd", 64'(buf_rd_en), 0);
    chk("t6_first", 64'(buf_rd_first_word_en), 0);
    chk("t6_ready", 64'(s_desc_ready), 0);
    chk("t6_tvalid", 64'(m_axis_tvalid), 0);
    chk("t6_tdata", 64'(m_axis_tdata[31:0]), 0);
    chk("t6_stat", 64'(stat_pkt_count), 0);
    chk("t6_err", 64'(err_len_mismatch), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    chk("t6_idle_ready", 64'(s_desc_ready), 1);
    chk("t6_no_issue", 64'(first_cyc.size() + rd_cyc.size()), 0);
    send(12'h500, 8'd2);
    wait_beats(2);
    chk("t6_nbeats", 64'(beat_q.size()), 2);
    chk("t6_beat0", 64'(beat_q[0]), 64'({1'b0, w(12'h500, 0)}));
    chk("t6_beat1", 64'(beat_q[1]), 64'({1'b1, w(12'h500, 1)}));
    chk("t6_stat_after", 64'(stat_pkt_count), 1);
    chk("t6_err_after", 64'(err_len_mismatch), 0);

    // zero-length descriptor behaves as one word and flags an error
    clear_logs();
    send(12'h600, 8'd0);
    wait_beats(1);
    repeat (3) @(negedge clk);
    chk("t7_nfirst", 64'(first_cyc.size()), 1);
    chk("t7_nrd", 64'(rd_cyc.size()), 0);
    chk("t7_beat", 64'(beat_q[0]), 64'({1'b1, w(12'h600, 0)}));
    chk("t7_err", 64'(err_len_mismatch), 1);
    chk("t7_stat", 64'(stat_pkt_count), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
